// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing
// with a memory-ready stall counter that traps to FAULT. Define MC_CONTROL_BNE_EN to decode BNE.
module mc_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int ALUOP_W     = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_i,
    input  logic [5:0]         opcode_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               pc_write_o,
    output logic               ir_write_o,
    output logic               iord_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               reg_write_o,
    output logic [1:0]         reg_dst_o,
    output logic [1:0]         mem_to_reg_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic [1:0]         pc_src_o,
    output logic               retire_o,
    output logic               fault_o,
    output logic [3:0]         state_o
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [5:0] OP_RFMT = 6'd0;
    localparam logic [5:0] OP_JAL  = 6'd3;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_ANDI = 6'd12;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;
`ifdef MC_CONTROL_BNE_EN
    localparam logic [5:0] OP_BNE  = 6'd5;
`endif

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(2'b00);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2'b10);
    localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(2'b11);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_FAULT    = 4'd12
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               pc_write_c, ir_write_c, iord_c, mem_read_c, mem_write_c;
    logic               reg_write_c, alu_src_a_c, retire_c, fault_c;
    logic [1:0]         reg_dst_c, mem_to_reg_c, alu_src_b_c, pc_src_c;
    logic [ALUOP_W-1:0] alu_op_c;
    logic               stall;
    logic               at_limit;

    assign at_limit = (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_write_c   = 1'b0;
        ir_write_c   = 1'b0;
        iord_c       = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        reg_dst_c    = 2'b00;
        mem_to_reg_c = 2'b00;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = 2'b00;
        alu_op_c     = ALU_ADD;
        pc_src_c     = 2'b00;
        retire_c     = 1'b0;
        fault_c      = 1'b0;
        stall        = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (run_i) begin
                    mem_read_c  = 1'b1;
                    alu_src_b_c = 2'b01;
                    if (mem_ready_i) begin
                        ir_write_c = 1'b1;
                        pc_write_c = 1'b1;
                        state_d    = S_DECODE;
                    end else begin
                        stall = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                alu_src_b_c = 2'b11;
                case (opcode_i)
                    OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                    OP_RFMT:          state_d = S_R_EXEC;
                    OP_ADDI, OP_ANDI: state_d = S_I_EXEC;
                    OP_BEQ:           state_d = S_BRANCH;
`ifdef MC_CONTROL_BNE_EN
                    OP_BNE:           state_d = S_BRANCH;
`endif
                    OP_JAL:           state_d = S_JAL;
                    default:          state_d = S_FAULT;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                if (opcode_i == OP_LW)      state_d = S_MEM_RD;
                else if (opcode_i == OP_SW) state_d = S_MEM_WR;
                else                        state_d = S_FAULT;
            end
            S_MEM_RD: begin
                mem_read_c = 1'b1;
                iord_c     = 1'b1;
                if (mem_ready_i) state_d = S_MEM_WB;
                else             stall   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 2'b01;
                retire_c     = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write_c = 1'b1;
                iord_c      = 1'b1;
                if (mem_ready_i) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    stall = 1'b1;
                end
            end
            S_R_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALU_FUNCT;
                state_d     = S_R_WB;
            end
            S_R_WB: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 2'b01;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = 2'b10;
                alu_op_c    = (opcode_i == OP_ANDI) ? ALU_AND : ALU_ADD;
                state_d     = S_I_WB;
            end
            S_I_WB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALU_SUB;
                pc_src_c    = 2'b01;
`ifdef MC_CONTROL_BNE_EN
                pc_write_c  = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
`else
                pc_write_c  = zero_i;
`endif
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                reg_write_c  = 1'b1;
                reg_dst_c    = 2'b10;
                mem_to_reg_c = 2'b10;
                pc_write_c   = 1'b1;
                pc_src_c     = 2'b10;
                retire_c     = 1'b1;
                state_d      = S_FETCH;
            end
            S_FAULT: begin
                fault_c = 1'b1;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase

        // Timeout only redirects the next state; this cycle's strobes stand
        if (stall && at_limit) state_d = S_FAULT;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_FETCH && !run_i)
            cnt_d = '0;
        else if (state_d != state_q)
            cnt_d = '0;
        else if (stall)
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Hold every output low while reset is asserted so no partial writeback escapes
    assign pc_write_o   = rst_n & pc_write_c;
    assign ir_write_o   = rst_n & ir_write_c;
    assign iord_o       = rst_n & iord_c;
    assign mem_read_o   = rst_n & mem_read_c;
    assign mem_write_o  = rst_n & mem_write_c;
    assign reg_write_o  = rst_n & reg_write_c;
    assign reg_dst_o    = rst_n ? reg_dst_c    : 2'b00;
    assign mem_to_reg_o = rst_n ? mem_to_reg_c : 2'b00;
    assign alu_src_a_o  = rst_n & alu_src_a_c;
    assign alu_src_b_o  = rst_n ? alu_src_b_c  : 2'b00;
    assign alu_op_o     = rst_n ? alu_op_c     : '0;
    assign pc_src_o     = rst_n ? pc_src_c     : 2'b00;
    assign retire_o     = rst_n & retire_c;
    assign fault_o      = rst_n & fault_c;
    assign state_o      = rst_n ? state_q      : 4'd0;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: per-cycle expected control words queued by the driver,
// popped and compared by a monitor on the falling edge.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run_i = 1'b0;
    logic [5:0] opcode_i = 6'd0;
    logic       zero_i = 1'b0;
    logic       mem_ready_i = 1'b0;

    logic       pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o, reg_write_o;
    logic [1:0] reg_dst_o, mem_to_reg_o, alu_src_b_o, alu_op_o, pc_src_o;
    logic       alu_src_a_o, retire_o, fault_o;
    logic [3:0] state_o;

    mc_control #(.MEM_TIMEOUT(15), .ALUOP_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .run_i(run_i), .opcode_i(opcode_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .ir_write_o(ir_write_o),
        .iord_o(iord_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
        .pc_src_o(pc_src_o), .retire_o(retire_o), .fault_o(fault_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, irw, iord, mr, mw, rw;
        logic [1:0] rd, m2r;
        logic       asa;
        logic [1:0] asb, aop, pcs;
        logic       ret, flt;
        logic [3:0] st;
    } ctl_t;

    ctl_t got;
    assign got = {pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o, reg_write_o,
                  reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o,
                  retire_o, fault_o, state_o};

    ctl_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_pass = 0;

    ctl_t E_IDLE, E_FW, E_FG, E_DEC, E_MADDR, E_MRD, E_MWB, E_MWW, E_MWG;
    ctl_t E_REX, E_RWB, E_IEA, E_IEN, E_IWB, E_BRN, E_BRT, E_JAL, E_FLT;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    endtask

    function automatic ctl_t st_only(input logic [3:0] s);
        ctl_t c;
        c = '0;
        c.st = s;
        return c;
    endfunction

    task automatic drv(input logic r, input logic [5:0] op, input logic z, input logic rdy,
                       input ctl_t e, input string t);
        @(negedge clk);
        #1;
        run_i = r; opcode_i = op; zero_i = z; mem_ready_i = rdy;
        exp_q.push_back(e);
        tag_q.push_back(t);
    endtask

    task automatic pulse_reset(input string t);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        run_i = 1'b0;
        #1;
        check(t, 32'(got), 32'(0));
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always begin
        @(negedge clk);
        #2;
        if (exp_q.size() > 0) begin
            ctl_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, 32'(got), 32'(e));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        E_IDLE = st_only(4'd0);
        E_FW = st_only(4'd0);  E_FW.mr = 1'b1; E_FW.asb = 2'b01;
        E_FG = E_FW;           E_FG.pcw = 1'b1; E_FG.irw = 1'b1;
        E_DEC = st_only(4'd1); E_DEC.asb = 2'b11;
        E_MADDR = st_only(4'd2); E_MADDR.asa = 1'b1; E_MADDR.asb = 2'b10;
        E_MRD = st_only(4'd3); E_MRD.mr = 1'b1; E_MRD.iord = 1'b1;
        E_MWB = st_only(4'd4); E_MWB.rw = 1'b1; E_MWB.m2r = 2'b01; E_MWB.ret = 1'b1;
        E_MWW = st_only(4'd5); E_MWW.mw = 1'b1; E_MWW.iord = 1'b1;
        E_MWG = E_MWW;         E_MWG.ret = 1'b1;
        E_REX = st_only(4'd6); E_REX.asa = 1'b1; E_REX.aop = 2'b10;
        E_RWB = st_only(4'd7); E_RWB.rw = 1'b1; E_RWB.rd = 2'b01; E_RWB.ret = 1'b1;
        E_IEA = st_only(4'd8); E_IEA.asa = 1'b1; E_IEA.asb = 2'b10;
        E_IEN = E_IEA;         E_IEN.aop = 2'b11;
        E_IWB = st_only(4'd9); E_IWB.rw = 1'b1; E_IWB.ret = 1'b1;
        E_BRN = st_only(4'd10); E_BRN.asa = 1'b1; E_BRN.aop = 2'b01; E_BRN.pcs = 2'b01;
        E_BRN.ret = 1'b1;
        E_BRT = E_BRN;         E_BRT.pcw = 1'b1;
        E_JAL = st_only(4'd11); E_JAL.rw = 1'b1; E_JAL.rd = 2'b10; E_JAL.m2r = 2'b10;
        E_JAL.pcw = 1'b1; E_JAL.pcs = 2'b10; E_JAL.ret = 1'b1;
        E_FLT = st_only(4'd12); E_FLT.flt = 1'b1;

        // Inputs that would fetch are held active; reset must still force all outputs low
        run_i = 1'b1; mem_ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("reset_outputs", 32'(got), 32'(0));
        @(negedge clk);
        #1;
        rst_n = 1'b1; run_i = 1'b0;

        drv(0, 6'd0, 0, 1, E_IDLE, "idle_run0");

        drv(1, 6'd0, 0, 1, E_FG,  "r_fetch");
        drv(1, 6'd0, 0, 1, E_DEC, "r_decode");
        drv(1, 6'd0, 0, 1, E_REX, "r_exec");
        drv(1, 6'd0, 0, 1, E_RWB, "r_wb");

        drv(1, 6'd35, 0, 1, E_FG,    "lw_fetch");
        drv(1, 6'd35, 0, 1, E_DEC,   "lw_decode");
        drv(1, 6'd35, 0, 1, E_MADDR, "lw_addr");
        for (int i = 0; i < 3; i++) drv(1, 6'd35, 0, 0, E_MRD, "lw_rd_stall");
        drv(1, 6'd35, 0, 1, E_MRD,   "lw_rd_done");
        drv(1, 6'd35, 0, 1, E_MWB,   "lw_wb");

        drv(1, 6'd43, 0, 1, E_FG,    "sw_fetch");
        drv(1, 6'd43, 0, 1, E_DEC,   "sw_decode");
        drv(1, 6'd43, 0, 1, E_MADDR, "sw_addr");
        drv(1, 6'd43, 0, 1, E_MWG,   "sw_wr");

        drv(1, 6'd8, 0, 0, E_FW,  "addi_fetch_stall");
        drv(1, 6'd8, 0, 0, E_FW,  "addi_fetch_stall");
        drv(1, 6'd8, 0, 1, E_FG,  "addi_fetch");
        drv(1, 6'd8, 0, 1, E_DEC, "addi_decode");
        drv(1, 6'd8, 0, 1, E_IEA, "addi_exec");
        drv(1, 6'd8, 0, 1, E_IWB, "addi_wb");

        drv(1, 6'd12, 0, 1, E_FG,  "andi_fetch");
        drv(1, 6'd12, 0, 1, E_DEC, "andi_decode");
        drv(1, 6'd12, 0, 1, E_IEN, "andi_exec");
        drv(1, 6'd12, 0, 1, E_IWB, "andi_wb");

        drv(1, 6'd4, 1, 1, E_FG,  "beq_t_fetch");
        drv(1, 6'd4, 1, 1, E_DEC, "beq_t_decode");
        drv(1, 6'd4, 1, 1, E_BRT, "beq_taken");
        drv(1, 6'd4, 0, 1, E_FG,  "beq_n_fetch");
        drv(1, 6'd4, 0, 1, E_DEC, "beq_n_decode");
        drv(1, 6'd4, 0, 1, E_BRN, "beq_not_taken");

        drv(1, 6'd3, 0, 1, E_FG,  "jal_fetch");
        drv(1, 6'd3, 0, 1, E_DEC, "jal_decode");
        drv(1, 6'd3, 0, 1, E_JAL, "jal_exec");

        // Ready arriving on the 16th stalled cycle completes the store normally
        drv(1, 6'd43, 0, 1, E_FG,    "swl_fetch");
        drv(1, 6'd43, 0, 1, E_DEC,   "swl_decode");
        drv(1, 6'd43, 0, 1, E_MADDR, "swl_addr");
        for (int i = 0; i < 15; i++) drv(1, 6'd43, 0, 0, E_MWW, "swl_stall");
        drv(1, 6'd43, 0, 1, E_MWG,   "swl_limit_ready");
        drv(1, 6'd0, 0, 1, E_FG,     "swl_next_fetch");
        drv(1, 6'd0, 0, 1, E_DEC,    "swl_next_decode");
        drv(1, 6'd0, 0, 1, E_REX,    "swl_next_exec");
        drv(1, 6'd0, 0, 1, E_RWB,    "swl_next_wb");

`ifdef MC_CONTROL_BNE_EN
        drv(1, 6'd5, 0, 1, E_FG,  "bne_t_fetch");
        drv(1, 6'd5, 0, 1, E_DEC, "bne_t_decode");
        drv(1, 6'd5, 0, 1, E_BRT, "bne_taken");
        drv(1, 6'd5, 1, 1, E_FG,  "bne_n_fetch");
        drv(1, 6'd5, 1, 1, E_DEC, "bne_n_decode");
        drv(1, 6'd5, 1, 1, E_BRN, "bne_not_taken");
`else
        drv(1, 6'd5, 0, 1, E_FG,  "op5_fetch");
        drv(1, 6'd5, 0, 1, E_DEC, "op5_decode");
        drv(1, 6'd5, 0, 1, E_FLT, "op5_fault");
        drv(1, 6'd0, 0, 1, E_FLT, "op5_fault_sticky");
        pulse_reset("op5_reset");
`endif

        drv(1, 6'd2, 0, 1, E_FG,  "ill_fetch");
        drv(1, 6'd2, 0, 1, E_DEC, "ill_decode");
        drv(1, 6'd2, 0, 1, E_FLT, "ill_fault");
        pulse_reset("ill_reset");

        drv(1, 6'd43, 0, 1, E_FG,    "to_fetch");
        drv(1, 6'd43, 0, 1, E_DEC,   "to_decode");
        drv(1, 6'd43, 0, 1, E_MADDR, "to_addr");
        for (int i = 0; i < 16; i++) drv(1, 6'd43, 0, 0, E_MWW, "to_stall");
        for (int i = 0; i < 3; i++) drv(1, 6'd0, 0, 1, E_FLT, "to_fault_sticky");
        pulse_reset("to_reset");
        drv(0, 6'd0, 0, 1, E_IDLE, "to_post_reset_idle");

        drv(1, 6'd0, 0, 1, E_FG,  "rr_fetch");
        drv(1, 6'd0, 0, 1, E_DEC, "rr_decode");
        drv(1, 6'd0, 0, 1, E_REX, "rr_exec");
        drv(1, 6'd0, 0, 1, E_RWB, "rr_wb");
        #2;
        rst_n = 1'b0;
        run_i = 1'b0;
        #1;
        check("rr_reset_reg_write", 32'(reg_write_o), 32'(0));
        check("rr_reset_state", 32'(state_o), 32'(0));
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drv(1, 6'd0, 0, 1, E_FG,  "rr_restart_fetch");
        drv(1, 6'd0, 0, 1, E_DEC, "rr_restart_decode");

        @(negedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
